// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction RAM writer. Consumes a little-endian
//                byte stream (32-bit word count N, N payload words, one
//                checksum byte), writes each word into instruction RAM and
//                releases the core reset once the checksum matches.
//  Ports       : clk, rst (sync, active-low)
//                s_valid/s_data/s_ready  - byte stream in
//                ram_ena/ram_wea/ram_addr/ram_w_data - RAM write port
//                cpu_rst (active-low core reset), done, error - status
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        ram_ena,
    output logic [3:0]  ram_wea,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_w_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] word_q, word_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic        s_ready_q, s_ready_d;
    logic        ram_ena_q, ram_ena_d;
    logic [3:0]  ram_wea_q, ram_wea_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_w_data_q, ram_w_data_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        hs;
    logic [31:0] count_shift;
    logic [31:0] word_shift;

    assign hs = s_valid && s_ready_q;
    // Little-endian assembly: each new byte enters at the top, so after four
    // shifts the first byte sits in [7:0].
    assign count_shift = {s_data, count_q[31:8]};
    assign word_shift  = {s_data, word_q[31:8]};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_d       = word_q;
        word_idx_d   = word_idx_q;
        byte_cnt_d   = byte_cnt_q;
        sum_d        = sum_q;
        ram_ena_d    = 1'b0;
        ram_wea_d    = 4'h0;
        ram_addr_d   = ram_addr_q;
        ram_w_data_d = ram_w_data_q;

        case (state_q)
            ST_HDR: begin
                if (hs) begin
                    count_d    = count_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (count_shift > C_DEPTH) begin
                            state_d = ST_ERR;
                        end else if (count_shift == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (hs) begin
                    word_d     = word_shift;
                    sum_d      = sum_q + s_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        ram_ena_d    = 1'b1;
                        ram_wea_d    = 4'hF;
                        ram_addr_d   = BASE_ADDR + (word_idx_q << 2);
                        ram_w_data_d = word_shift;
                        word_idx_d   = word_idx_q + 32'd1;
                        if (word_idx_q == count_q - 32'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (hs) begin
                    state_d = (s_data == sum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

        // Status flags track the state being entered so they change in the
        // cycle right after the deciding handshake.
        s_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d    = (state_d == ST_DONE);
        cpu_rst_d = (state_d == ST_DONE);
        error_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_HDR;
            count_q      <= 32'd0;
            word_q       <= 32'd0;
            word_idx_q   <= 32'd0;
            byte_cnt_q   <= 2'd0;
            sum_q        <= 8'd0;
            s_ready_q    <= 1'b0;
            ram_ena_q    <= 1'b0;
            ram_wea_q    <= 4'h0;
            ram_addr_q   <= BASE_ADDR;
            ram_w_data_q <= 32'd0;
            cpu_rst_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_q       <= word_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            sum_q        <= sum_d;
            s_ready_q    <= s_ready_d;
            ram_ena_q    <= ram_ena_d;
            ram_wea_q    <= ram_wea_d;
            ram_addr_q   <= ram_addr_d;
            ram_w_data_q <= ram_w_data_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign ram_ena    = ram_ena_q;
    assign ram_wea    = ram_wea_q;
    assign ram_addr   = ram_addr_q;
    assign ram_w_data = ram_w_data_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
`default_nettype wire
